// File: rtl/read_rw_issue.sv
// Read-issue stage of the RW pipeline: allocates a thread per task, reads the data-array line
// and hands {task, object, cq_slot, thread} to the write stage; undo restores bypass the read.
package read_rw_issue_pkg;
    typedef logic [3:0]   thread_id_t;
    typedef logic [7:0]   cq_slice_slot_t;
    typedef logic [511:0] object_t;

    typedef enum logic [1:0] {
        TASK_TYPE_READ,
        TASK_TYPE_WRITE,
        TASK_TYPE_RMW,
        TASK_TYPE_UNDO_LOG_RESTORE
    } task_type_t;

    typedef struct packed {
        task_type_t  ttype;
        logic [31:0] locale;
        logic [31:0] ts;
    } task_t;

    typedef struct packed {
        task_t          task_desc;
        object_t        object;
        cq_slice_slot_t cq_slot;
        thread_id_t     thread;
    } rw_write_t;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } reg_bus_req_t;

    typedef struct packed {
        logic        rvalid;
        logic [31:0] rdata;
    } reg_bus_rsp_t;

    localparam logic [7:0] RW_BASE_ADDR = 8'h04;
endpackage

module read_rw_issue
    import read_rw_issue_pkg::*;
#(
    parameter int TILE_ID      = 0,
    parameter int N_THREADS    = 8,
    parameter int LOG_RW_WIDTH = 2
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           task_in_valid_i,
    output logic           task_in_ready_o,
    input  task_t          task_in_i,
    input  cq_slice_slot_t task_in_cq_slot_i,
    input  object_t        task_in_object_i,
    output logic           arvalid_o,
    input  logic           arready_i,
    output logic [31:0]    araddr_o,
    output thread_id_t     arid_o,
    input  logic           rvalid_i,
    output logic           rready_o,
    input  logic [511:0]   rdata_i,
    input  thread_id_t     rid_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output rw_write_t      out_o,
    input  logic           unlock_locale_i,
    input  thread_id_t     unlock_thread_i,
    input  reg_bus_req_t   reg_bus_i,
    output reg_bus_rsp_t   reg_bus_o
);
    if (N_THREADS < 1 || N_THREADS > 2 ** $bits(thread_id_t) || TILE_ID < 0 ||
        LOG_RW_WIDTH < 2 || LOG_RW_WIDTH > 6) begin : g_bad_params
        $error("read_rw_issue: invalid parameters");
    end

    localparam int      ObjW    = 8 << LOG_RW_WIDTH;
    localparam object_t ObjMask = (ObjW >= 512) ? '1 : ((object_t'(1) << ObjW) - object_t'(1));

    typedef struct packed {
        task_t          task_desc;
        cq_slice_slot_t cq_slot;
    } entry_t;

    logic [N_THREADS-1:0] busy_q, busy_d;
    entry_t               table_q [N_THREADS];
    logic                 out_valid_q, out_valid_d;
    rw_write_t            out_q, out_d;
    logic [31:0]          base_q, base_d;
    reg_bus_rsp_t         reg_rsp_q, reg_rsp_d;

    logic        anyFree, isUndo, outFree, arFire, rFire, rHit, rHitBusy, undoAccept;
    thread_id_t  allocId;
    entry_t      rEntry;
    logic [31:0] inFlight;
    logic [5:0]  rByteOff;
    object_t     rObject;
    logic        unusedBits;

    // Lowest-index free thread wins allocation; the same scan counts in-flight threads.
    always_comb begin
        anyFree  = 1'b0;
        allocId  = '0;
        inFlight = '0;
        for (int i = N_THREADS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                anyFree = 1'b1;
                allocId = thread_id_t'(i);
            end
            inFlight = inFlight + 32'(busy_q[i]);
        end
    end

    always_comb begin
        rHitBusy = 1'b0;
        rEntry   = '0;
        for (int i = 0; i < N_THREADS; i++) begin
            if (rid_i == thread_id_t'(i)) begin
                rHitBusy = busy_q[i];
                rEntry   = table_q[i];
            end
        end
    end

    assign isUndo          = (task_in_i.ttype == TASK_TYPE_UNDO_LOG_RESTORE);
    assign outFree         = !out_valid_q || out_ready_i;
    assign rready_o        = outFree;
    assign rFire           = rvalid_i && outFree;
    assign rHit            = rFire && rHitBusy;
    assign arvalid_o       = rstn && task_in_valid_i && !isUndo && anyFree;
    assign arFire          = arvalid_o && arready_i;
    // A response taking the output register this cycle pushes any undo restore back a cycle.
    assign undoAccept      = rstn && task_in_valid_i && isUndo && anyFree && outFree && !rFire;
    assign task_in_ready_o = arFire || undoAccept;
    assign araddr_o        = base_q + (task_in_i.locale << LOG_RW_WIDTH);
    assign arid_o          = allocId;
    assign rByteOff        = 6'(rEntry.task_desc.locale << LOG_RW_WIDTH);
    assign rObject         = (rdata_i >> {rByteOff, 3'b000}) & ObjMask;
    assign unusedBits      = ^reg_bus_i.wdata[31:30];

    always_comb begin
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        base_d      = base_q;
        for (int i = 0; i < N_THREADS; i++) begin
            if (unlock_locale_i && unlock_thread_i == thread_id_t'(i)) busy_d[i] = 1'b0;
            if ((arFire || undoAccept) && allocId == thread_id_t'(i)) busy_d[i] = 1'b1;
        end
        if (rHit) begin
            out_valid_d       = 1'b1;
            out_d.task_desc   = rEntry.task_desc;
            out_d.object      = rObject;
            out_d.cq_slot     = rEntry.cq_slot;
            out_d.thread      = rid_i;
        end else if (undoAccept) begin
            out_valid_d       = 1'b1;
            out_d.task_desc   = task_in_i;
            out_d.object      = task_in_object_i;
            out_d.cq_slot     = task_in_cq_slot_i;
            out_d.thread      = allocId;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
        if (reg_bus_i.valid && reg_bus_i.write && reg_bus_i.addr == RW_BASE_ADDR)
            base_d = {reg_bus_i.wdata[29:0], 2'b00};
        reg_rsp_d.rvalid = arvalid_o;
        reg_rsp_d.rdata  = inFlight;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            base_q      <= '0;
            reg_rsp_q   <= '0;
        end else begin
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            base_q      <= base_d;
            reg_rsp_q   <= reg_rsp_d;
        end
    end

    // The task table needs no reset: an entry is only read while its thread is busy.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_THREADS; i++) begin
            if (arFire && allocId == thread_id_t'(i)) begin
                table_q[i].task_desc <= task_in_i;
                table_q[i].cq_slot   <= task_in_cq_slot_i;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_o       = out_q;
    assign reg_bus_o   = reg_rsp_q;
endmodule

// File: tb/tb_read_rw_issue.sv
// Bench for read_rw_issue: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a thread-table model of the read-issue stage.
module tb_read_rw_issue;
    import read_rw_issue_pkg::*;

    localparam int NT  = 4;
    localparam int LOG = 2;

    logic           clk;
    logic           rstn;
    logic           taskInValid, taskInReady;
    task_t          taskIn;
    cq_slice_slot_t taskInSlot;
    object_t        taskInObject;
    logic           arvalid, arready;
    logic [31:0]    araddr;
    thread_id_t     arid;
    logic           rvalid, rready;
    logic [511:0]   rdata;
    thread_id_t     rid;
    logic           outValid, outReady;
    rw_write_t      outW;
    logic           unlockLocale;
    thread_id_t     unlockThread;
    reg_bus_req_t   regReq;
    reg_bus_rsp_t   regRsp;

    read_rw_issue #(.TILE_ID(0), .N_THREADS(NT), .LOG_RW_WIDTH(LOG)) dut (
        .clk(clk), .rstn(rstn),
        .task_in_valid_i(taskInValid), .task_in_ready_o(taskInReady),
        .task_in_i(taskIn), .task_in_cq_slot_i(taskInSlot), .task_in_object_i(taskInObject),
        .arvalid_o(arvalid), .arready_i(arready), .araddr_o(araddr), .arid_o(arid),
        .rvalid_i(rvalid), .rready_o(rready), .rdata_i(rdata), .rid_i(rid),
        .out_valid_o(outValid), .out_ready_i(outReady), .out_o(outW),
        .unlock_locale_i(unlockLocale), .unlock_thread_i(unlockThread),
        .reg_bus_i(regReq), .reg_bus_o(regRsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    bit             mBusy [NT];
    task_t          mTask [NT];
    cq_slice_slot_t mSlot [NT];
    logic [31:0]    mBase;
    bit             mOutValid;
    rw_write_t      mOut;
    bit             mRegRvalid;
    int             mRegCnt;
    bit             expAr, rAcc, undoAcc;
    int             expArid;

    task automatic checkVal(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int lowestFree();
        for (int i = 0; i < NT; i++) if (!mBusy[i]) return i;
        return -1;
    endfunction

    task automatic resetModel();
        for (int i = 0; i < NT; i++) mBusy[i] = 0;
        mBase      = '0;
        mOutValid  = 0;
        mOut       = '0;
        mRegRvalid = 0;
        mRegCnt    = 0;
    endtask

    // Predict this cycle's handshakes from the model and compare everything visible.
    task automatic checkOutput();
        int lf;
        bit anyFree, undo, outFree;
        logic [31:0] expAddr;
        lf      = lowestFree();
        anyFree = (lf >= 0);
        undo    = (taskIn.ttype == TASK_TYPE_UNDO_LOG_RESTORE);
        outFree = !mOutValid || outReady;
        expAr   = rstn && taskInValid && !undo && anyFree;
        expArid = anyFree ? lf : 0;
        expAddr = mBase + taskIn.locale * (32'd1 << LOG);
        rAcc    = rvalid && outFree;
        undoAcc = rstn && taskInValid && undo && anyFree && outFree && !rAcc;
        checkVal("arvalid", 64'(arvalid), 64'(expAr));
        if (expAr) begin
            checkVal("arid", 64'(arid), 64'(expArid));
            checkVal("araddr", 64'(araddr), 64'(expAddr));
        end
        checkVal("task_in_ready", 64'(taskInReady), 64'((expAr && arready) || undoAcc));
        checkVal("rready", 64'(rready), 64'(outFree));
        checkVal("out_valid", 64'(outValid), 64'(mOutValid));
        if (mOutValid) begin
            checkVal("out.thread", 64'(outW.thread), 64'(mOut.thread));
            checkVal("out.cq_slot", 64'(outW.cq_slot), 64'(mOut.cq_slot));
            checkVal("out.locale", 64'(outW.task_desc.locale), 64'(mOut.task_desc.locale));
            checkVal("out.object", outW.object[63:0], mOut.object[63:0]);
            checkVal("out.whole", 64'(outW === mOut), 64'd1);
        end
        checkVal("reg rvalid", 64'(regRsp.rvalid), 64'(mRegRvalid));
        checkVal("reg rdata", 64'(regRsp.rdata), 64'(mRegCnt));
    endtask

    task automatic settle();
        #1;
        checkOutput();
    endtask

    // Clock edge, then advance the model by the events of the cycle just ended.
    task automatic advance();
        int cnt, lf;
        logic [511:0] sh;
        @(posedge clk);
        if (!rstn) begin
            resetModel();
        end else begin
            cnt = 0;
            for (int i = 0; i < NT; i++) cnt += int'(mBusy[i]);
            mRegRvalid = expAr;
            mRegCnt    = cnt;
            lf = lowestFree();
            if (rAcc && int'(rid) < NT && mBusy[int'(rid)]) begin
                sh = rdata >> (32 * (mTask[int'(rid)].locale % 16));
                mOut.task_desc = mTask[int'(rid)];
                mOut.object    = object_t'(sh[31:0]);
                mOut.cq_slot   = mSlot[int'(rid)];
                mOut.thread    = rid;
                mOutValid      = 1;
            end else if (undoAcc) begin
                mOut.task_desc = taskIn;
                mOut.object    = taskInObject;
                mOut.cq_slot   = taskInSlot;
                mOut.thread    = thread_id_t'(lf);
                mOutValid      = 1;
            end else if (outReady) begin
                mOutValid = 0;
            end
            if (unlockLocale && int'(unlockThread) < NT) mBusy[int'(unlockThread)] = 0;
            if ((expAr && arready) || undoAcc) begin
                mBusy[expArid] = 1;
                if (expAr) begin
                    mTask[expArid] = taskIn;
                    mSlot[expArid] = taskInSlot;
                end
            end
            if (regReq.valid && regReq.write && regReq.addr == RW_BASE_ADDR)
                mBase = regReq.wdata << 2;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rstn         = 1'b1;
        taskInValid  = 1'b0;
        taskIn       = '0;
        taskInSlot   = '0;
        taskInObject = '0;
        arready      = 1'b0;
        rvalid       = 1'b0;
        rdata        = '0;
        rid          = '0;
        outReady     = 1'b1;
        unlockLocale = 1'b0;
        unlockThread = '0;
        regReq       = '0;
    endtask

    task automatic issue(logic [31:0] locale, cq_slice_slot_t slot);
        idle();
        taskInValid   = 1'b1;
        taskIn.ttype  = TASK_TYPE_READ;
        taskIn.locale = locale;
        taskIn.ts     = $urandom;
        taskInSlot    = slot;
        arready       = 1'b1;
    endtask

    task automatic unlockAll();
        for (int i = 0; i < NT; i++) begin
            idle();
            unlockLocale = 1'b1;
            unlockThread = thread_id_t'(i);
            settle();
            advance();
        end
    endtask

    task automatic applyStimulus();
        int q[$];
        rstn          = ($urandom_range(0, 299) != 0);
        taskInValid   = ($urandom_range(0, 3) != 0);
        taskIn.ttype  = ($urandom_range(0, 7) == 0) ? TASK_TYPE_UNDO_LOG_RESTORE
                                                     : task_type_t'(2'($urandom_range(0, 2)));
        taskIn.locale = $urandom;
        taskIn.ts     = $urandom;
        taskInSlot    = 8'($urandom);
        taskInObject  = object_t'({$urandom, $urandom});
        arready       = ($urandom_range(0, 3) != 0);
        rvalid        = ($urandom_range(0, 2) == 0);
        for (int i = 0; i < NT; i++) if (mBusy[i]) q.push_back(i);
        if (q.size() > 0 && $urandom_range(0, 7) != 0) rid = thread_id_t'(q[$urandom_range(0, q.size() - 1)]);
        else rid = thread_id_t'($urandom_range(0, 15));
        for (int k = 0; k < 16; k++) rdata[k*32 +: 32] = $urandom;
        outReady      = ($urandom_range(0, 3) != 0);
        unlockLocale  = ($urandom_range(0, 3) == 0);
        unlockThread  = thread_id_t'($urandom_range(0, NT - 1));
        regReq.valid  = ($urandom_range(0, 31) == 0);
        regReq.write  = ($urandom_range(0, 1) == 1);
        regReq.addr   = ($urandom_range(0, 1) == 1) ? RW_BASE_ADDR : 8'($urandom);
        regReq.wdata  = $urandom;
    endtask

    int order[3] = '{2, 0, 1};

    initial begin
        idle();
        rstn = 1'b0;
        @(negedge clk);
        resetModel();

        // Reset state, even with a task offered.
        issue(32'd7, 8'h01);
        rstn = 1'b0;
        settle();
        checkVal("reset arvalid", 64'(arvalid), 64'd0);
        checkVal("reset task_in_ready", 64'(taskInReady), 64'd0);
        checkVal("reset out_valid", 64'(outValid), 64'd0);
        checkVal("reset reg rvalid", 64'(regRsp.rvalid), 64'd0);
        advance();

        // Base address write then locale 5 read, response word 5.
        idle();
        regReq = '{valid: 1'b1, write: 1'b1, addr: RW_BASE_ADDR, wdata: 32'h400};
        settle();
        advance();
        issue(32'd5, 8'h11);
        settle();
        checkVal("addr araddr", 64'(araddr), 64'h1014);
        checkVal("addr arid", 64'(arid), 64'd0);
        advance();
        idle();
        rvalid = 1'b1;
        rid = 4'd0;
        rdata[191:160] = 32'hDEADBEEF;
        settle();
        advance();
        idle();
        settle();
        checkVal("addr out_valid", 64'(outValid), 64'd1);
        checkVal("addr out.object", outW.object[63:0], 64'hDEADBEEF);
        checkVal("addr out.thread", 64'(outW.thread), 64'd0);
        advance();
        unlockAll();

        // Out-of-order responses keep their own cq_slot.
        for (int i = 0; i < 3; i++) begin
            issue(32'(i + 1), 8'(8'hA0 + i));
            settle();
            checkVal("ooo arid", 64'(arid), 64'(i));
            advance();
        end
        for (int k = 0; k < 4; k++) begin
            idle();
            if (k < 3) begin
                rvalid = 1'b1;
                rid = thread_id_t'(order[k]);
                for (int j = 0; j < 16; j++) rdata[j*32 +: 32] = $urandom;
            end
            settle();
            if (k > 0) begin
                checkVal("ooo out.thread", 64'(outW.thread), 64'(order[k-1]));
                checkVal("ooo out.cq_slot", 64'(outW.cq_slot), 64'(8'hA0 + order[k-1]));
            end
            advance();
        end
        unlockAll();

        // Fill every thread; the next task is held until an unlock lands.
        for (int i = 0; i < NT; i++) begin
            issue(32'(i), 8'(i));
            settle();
            advance();
        end
        issue(32'd9, 8'h99);
        settle();
        checkVal("full task_in_ready", 64'(taskInReady), 64'd0);
        checkVal("full arvalid", 64'(arvalid), 64'd0);
        advance();
        issue(32'd9, 8'h99);
        unlockLocale = 1'b1;
        unlockThread = 4'd1;
        settle();
        checkVal("unlock cycle arvalid", 64'(arvalid), 64'd0);
        advance();
        issue(32'd9, 8'h99);
        settle();
        checkVal("after unlock arvalid", 64'(arvalid), 64'd1);
        checkVal("after unlock arid", 64'(arid), 64'd1);
        advance();
        unlockAll();

        // Undo restore collides with a response: response first, restore next.
        issue(32'd3, 8'h30);
        settle();
        advance();
        idle();
        taskInValid  = 1'b1;
        taskIn.ttype = TASK_TYPE_UNDO_LOG_RESTORE;
        taskInSlot   = 8'h77;
        taskInObject = object_t'(8'h55);
        arready      = 1'b1;
        rvalid       = 1'b1;
        rid          = 4'd0;
        settle();
        checkVal("undo blocked ready", 64'(taskInReady), 64'd0);
        checkVal("undo arvalid", 64'(arvalid), 64'd0);
        advance();
        rvalid = 1'b0;
        settle();
        checkVal("undo resp thread", 64'(outW.thread), 64'd0);
        checkVal("undo accepted", 64'(taskInReady), 64'd1);
        advance();
        idle();
        settle();
        checkVal("undo out.object", outW.object[63:0], 64'h55);
        checkVal("undo out.thread", 64'(outW.thread), 64'd1);
        advance();
        unlockAll();

        // Output stall holds the register and back-pressures responses.
        for (int i = 0; i < 2; i++) begin
            issue(32'(i), 8'(8'h50 + i));
            settle();
            advance();
        end
        idle();
        outReady = 1'b0;
        rvalid = 1'b1;
        rid = 4'd0;
        settle();
        advance();
        for (int c = 0; c < 5; c++) begin
            idle();
            outReady = 1'b0;
            rvalid = 1'b1;
            rid = 4'd1;
            settle();
            checkVal("stall rready", 64'(rready), 64'd0);
            checkVal("stall out.thread", 64'(outW.thread), 64'd0);
            advance();
        end
        rvalid = 1'b1;
        rid = 4'd1;
        outReady = 1'b1;
        settle();
        checkVal("release rready", 64'(rready), 64'd1);
        advance();
        idle();
        settle();
        checkVal("drain out.thread", 64'(outW.thread), 64'd1);
        advance();
        unlockAll();

        // Reset with reads in flight; a late response is dropped.
        for (int i = 0; i < 3; i++) begin
            issue(32'(i), 8'(i));
            settle();
            advance();
        end
        issue(32'd4, 8'h44);
        rstn = 1'b0;
        settle();
        checkVal("mid reset arvalid", 64'(arvalid), 64'd0);
        advance();
        idle();
        rvalid = 1'b1;
        rid = 4'd1;
        settle();
        checkVal("post reset reg rdata", 64'(regRsp.rdata), 64'd0);
        advance();
        issue(32'd4, 8'h44);
        settle();
        checkVal("late rid out_valid", 64'(outValid), 64'd0);
        checkVal("post reset arid", 64'(arid), 64'd0);
        advance();
        unlockAll();

        for (int c = 0; c < 3000; c++) begin
            applyStimulus();
            settle();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/read_rw_issue.md
READ_RW_ISSUE -- requirements
Module: read_rw_issue

Interface
REQ-001 SHALL have parameter TILE_ID, default 0, tile index (informational only).
REQ-002 SHALL have parameter N_THREADS, default 8, in-flight read slots (≤ 2**$bits(thread_id_t)).
REQ-003 clk  in  1  clock.
REQ-004 rstn  in  1  reset, synchronous, active-low.
REQ-005 task_in_valid / task_in_ready  in / out  1 / 1  incoming task handshake.
REQ-006 task_in  in  task_t  task descriptor (ttype, locale, ...).
REQ-007 task_in_cq_slot  in  cq_slice_slot_t  commit-queue slot of the incoming task.
REQ-008 task_in_object  in  object_t  payload, used only for TASK_TYPE_UNDO_LOG_RESTORE.
REQ-009 arvalid / arready  out / in  1 / 1  data-array read request handshake.
REQ-010 araddr / arid  out / out  32 / thread_id_t  read address and tag.
REQ-011 rvalid / rready  in / out  1 / 1  read response handshake (any order across ids).
REQ-012 rdata / rid  in / in  512 / thread_id_t  response line and tag.
REQ-013 out_valid / out_ready  out / in  1 / 1  output handshake to write stage.
REQ-014 out  out  rw_write_t  {task_desc, object, cq_slot, thread}.
REQ-015 unlock_locale / unlock_thread  in / in  1 / thread_id_t  thread release from write stage.
REQ-016 reg_bus  reg_bus_t  register bus.

Function
REQ-017 SHALL keep a free bitmap of N_THREADS threads; allocation picks lowest-index free thread.
REQ-018 Normal task (ttype != UNDO_LOG_RESTORE): arvalid = task_in_valid & any_free; task_in_ready = arvalid & arready; no combinational path from out_ready to arvalid.
REQ-019 araddr = base_rw_addr + (locale << LOG_RW_WIDTH), 32-bit wrap; arid = allocated thread.
REQ-020 On arvalid&arready SHALL mark thread busy and store {task_desc, cq_slot} in table[thread].
REQ-021 rready = !out_valid | out_ready; on rvalid&rready load out register next cycle with table[rid], thread=rid, object = rdata slice selected by locale low bits (32b: locale[3:0]*32; 64b: [2:0]*64; 128b: [1:0]*128; 256b: [0]*256; 512b: whole line).
REQ-022 Undo restore task: no read issued; needs a free thread; accepted when any_free & output free & no response accepted that cycle; out loaded with task_in_object, allocated thread marked busy.
REQ-023 Priority for output register: read response > undo restore.
REQ-024 out_valid SHALL hold with out stable until out_ready; latency response-accept to out_valid = 1 cycle; throughput 1/cycle.
REQ-025 Thread freed on unlock_locale at next edge; freed thread allocatable the cycle after; allocate and free of different threads same cycle both take effect; unlock of free thread ignored.
REQ-026 Response with rid of a free thread SHALL be accepted and dropped (no out_valid).
REQ-027 All threads busy: arvalid=0, task_in_ready=0 until an unlock.
REQ-028 reg_bus write RW_BASE_ADDR SHALL set base_rw_addr = {wdata[29:0],2'b00}; reg_bus.rvalid = arvalid delayed one cycle; rdata = in-flight thread count.

Reset
REQ-029 On rstn=0: out_valid=0, arvalid=0, task_in_ready=0, all threads free, base_rw_addr=0, reg_bus.rvalid=0; in-flight state discarded.
REQ-030 Responses arriving after reset for pre-reset reads fall under REQ-026.

Verification
REQ-031 LOG_RW_WIDTH=2, base write 0x400, task locale=5 -> araddr=0x1014, arid=0; rdata[191:160]=0xDEADBEEF -> out.object=0xDEADBEEF, out.thread=0 one cycle later.
REQ-032 Issue threads 0,1,2; return rid 2,0,1 -> out order 2,0,1 with matching cq_slot each.
REQ-033 N_THREADS=2, 3 tasks, no unlock -> third held (task_in_ready=0); unlock_thread=1 -> third issued with arid=1 two cycles later.
REQ-034 Undo restore object 0x55 and rvalid same cycle -> response out first, restore next; restore never drives arvalid.
REQ-035 out_ready=0 for 5 cycles with pending rvalid -> rready=0, out stable; release -> drains in order.
REQ-036 Reset with 3 threads in flight -> all outputs per REQ-029; late rid=1 dropped, no out_valid.
